// File: rtl/bus_pkg.sv
// Definitions shared by the serial address/data bus master and slave.
package bus_pkg;
  localparam int ADDR_W  = 16;
  localparam int DATA_W  = 8;
  localparam int ACK_WIN = 4;
  localparam int ID_W    = 4;
  localparam int OFF_W   = ADDR_W - ID_W;
  localparam int CNT_W   = 4;

  localparam logic [CNT_W-1:0] CNT_ADDR_LAST = CNT_W'(ADDR_W - 1);
  localparam logic [CNT_W-1:0] CNT_DATA_LAST = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] CNT_WIN_LAST  = CNT_W'(ACK_WIN - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ACKA,
    ST_WDATA,
    ST_READ,
    ST_ACKW
  } bus_state_t;
endpackage

// File: rtl/counter.sv
// Free-running up counter with synchronous clear (clear wins over enable).
module counter #(
  parameter int WIDTH = 4
) (
  input  logic             CLK,
  input  logic             RSTN,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [WIDTH-1:0] count_o
);
  logic [WIDTH-1:0] count_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      count_q <= '0;
    end else if (clr_i) begin
      count_q <= '0;
    end else if (en_i) begin
      count_q <= count_q + WIDTH'(1);
    end
  end

  assign count_o = count_q;
endmodule

// File: rtl/bus_slave.sv
// Serial bus target: deserialises the address and write data, serialises read data
// and bridges each frame addressed to SLAVE_ID onto a byte-wide local port.
module bus_slave
  import bus_pkg::*;
#(
  parameter logic [ID_W-1:0] SLAVE_ID = 4'h0,
  parameter int              TIMEOUT  = 64
) (
  input  logic              CLK,
  input  logic              RSTN,
  input  logic              B_UTIL,
  input  logic              B_RW,
  input  logic              B_BUS_IN,
  output logic              B_BUS_OUT,
  output logic              B_ACK,
  output logic [OFF_W-1:0]  S_ADDR,
  output logic [DATA_W-1:0] S_WDATA,
  output logic              S_WE,
  output logic              S_RE,
  input  logic [DATA_W-1:0] S_RDATA,
  output logic              S_BSY
);
  localparam int               TO_W        = $clog2(TIMEOUT + 1);
  localparam logic [TO_W-1:0]  TO_LAST     = TO_W'(TIMEOUT - 1);
  localparam int               BIT_W       = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] CNT_RD_CAPT = CNT_W'(1);

  bus_state_t        state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] tx_q;
  logic [TO_W-1:0]   to_q;
  logic              rw_q, match_q;
  logic              b_bus_out_q, b_ack_q, s_we_q, s_re_q, s_bsy_q;

  logic [CNT_W-1:0]  cnt;
  logic [BIT_W-1:0]  bit_idx;
  logic              cnt_clr, cnt_en, id_match, to_hit;

  // Address arrives LSB first, so the device select is complete only with bit 15 on the wire.
  assign id_match = ({B_BUS_IN, addr_q[ADDR_W-1 -: ID_W-1]} == SLAVE_ID);
  assign to_hit   = (to_q == TO_LAST);
  assign bit_idx  = cnt[BIT_W-1:0];

  counter #(.WIDTH(CNT_W)) u_bit_cnt (
    .CLK     (CLK),
    .RSTN    (RSTN),
    .clr_i   (cnt_clr),
    .en_i    (cnt_en),
    .count_o (cnt)
  );

  // NOTE: both outputs get a default first so no path through the case infers a latch.
  always_comb begin
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
    case (state_q)
      ST_IDLE:  cnt_en = B_UTIL;
      ST_ADDR: begin
        cnt_clr = !B_UTIL || (cnt == CNT_ADDR_LAST);
        cnt_en  = !cnt_clr;
      end
      ST_ACKA, ST_ACKW: begin
        cnt_clr = (cnt == CNT_WIN_LAST);
        cnt_en  = !cnt_clr;
      end
      ST_WDATA, ST_READ: begin
        cnt_clr = B_UTIL ? (cnt == CNT_DATA_LAST) : to_hit;
        cnt_en  = B_UTIL && !cnt_clr;
      end
      default:  cnt_clr = 1'b1;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      tx_q        <= '0;
      to_q        <= '0;
      rw_q        <= 1'b0;
      match_q     <= 1'b0;
      b_bus_out_q <= 1'b0;
      b_ack_q     <= 1'b0;
      s_we_q      <= 1'b0;
      s_re_q      <= 1'b0;
      s_bsy_q     <= 1'b0;
    end else begin
      s_we_q <= 1'b0;
      s_re_q <= 1'b0;
      case (state_q)
        ST_IDLE: if (B_UTIL) begin
          addr_q  <= {B_BUS_IN, addr_q[ADDR_W-1:1]};
          state_q <= ST_ADDR;
          s_bsy_q <= 1'b1;
        end
        ST_ADDR: if (!B_UTIL) begin
          state_q <= ST_IDLE;
          s_bsy_q <= 1'b0;
        end else begin
          addr_q <= {B_BUS_IN, addr_q[ADDR_W-1:1]};
          if (cnt == CNT_ADDR_LAST) begin
            state_q <= ST_ACKA;
            rw_q    <= B_RW;
            match_q <= id_match;
            s_re_q  <= id_match && !B_RW;
          end
        end
        ST_ACKA: begin
          to_q    <= '0;
          b_ack_q <= match_q && (cnt != CNT_WIN_LAST);
          if (match_q && !rw_q && (cnt == CNT_RD_CAPT)) tx_q <= S_RDATA;
          if (cnt == CNT_WIN_LAST) begin
            if (!match_q) begin
              state_q <= ST_IDLE;
              s_bsy_q <= 1'b0;
            end else if (rw_q) begin
              state_q <= ST_WDATA;
            end else begin
              state_q     <= ST_READ;
              b_bus_out_q <= tx_q[0];
            end
          end
        end
        ST_WDATA: if (B_UTIL) begin
          wdata_q <= {B_BUS_IN, wdata_q[DATA_W-1:1]};
          to_q    <= '0;
          if (cnt == CNT_DATA_LAST) begin
            state_q <= ST_ACKW;
            s_we_q  <= 1'b1;
          end
        end else if (to_hit) begin
          state_q <= ST_IDLE;
          s_bsy_q <= 1'b0;
          to_q    <= '0;
        end else begin
          to_q <= to_q + TO_W'(1);
        end
        // A master hold leaves the current bit on the wire until the next B_UTIL cycle.
        ST_READ: if (B_UTIL) begin
          to_q <= '0;
          if (cnt == CNT_DATA_LAST) begin
            state_q     <= ST_IDLE;
            s_bsy_q     <= 1'b0;
            b_bus_out_q <= 1'b0;
          end else begin
            b_bus_out_q <= tx_q[bit_idx + BIT_W'(1)];
          end
        end else if (to_hit) begin
          state_q     <= ST_IDLE;
          s_bsy_q     <= 1'b0;
          b_bus_out_q <= 1'b0;
          to_q        <= '0;
        end else begin
          to_q <= to_q + TO_W'(1);
        end
        ST_ACKW: begin
          b_ack_q <= (cnt != CNT_WIN_LAST);
          if (cnt == CNT_WIN_LAST) begin
            state_q <= ST_IDLE;
            s_bsy_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          s_bsy_q     <= 1'b0;
          b_ack_q     <= 1'b0;
          b_bus_out_q <= 1'b0;
        end
      endcase
    end
  end

  assign B_BUS_OUT = b_bus_out_q;
  assign B_ACK     = b_ack_q;
  assign S_ADDR    = addr_q[OFF_W-1:0];
  assign S_WDATA   = wdata_q;
  assign S_WE      = s_we_q;
  assign S_RE      = s_re_q;
  assign S_BSY     = s_bsy_q;
endmodule

// File: tb/tb_bus_slave.sv
// Directed bench for bus_slave: table of whole frames plus hand-written sequences
// for address abort, data-phase timeout and reset in the middle of a write.
module tb_bus_slave;
  localparam int TMO = 64;

  logic        CLK = 1'b0;
  logic        RSTN = 1'b1;
  logic        B_UTIL = 1'b0, B_RW = 1'b0, B_BUS_IN = 1'b0;
  logic        B_BUS_OUT, B_ACK, S_WE, S_RE, S_BSY;
  logic [11:0] S_ADDR;
  logic [7:0]  S_WDATA, S_RDATA;
  logic [7:0]  mem_byte = 8'h00;
  logic [7:0]  rdata_q = 8'h00;

  int checks = 0;
  int errors = 0;

  logic        s_ack, s_out, s_we, s_re, s_bsy;
  logic [11:0] s_addr;
  logic [7:0]  s_wdata;

  bus_slave #(.SLAVE_ID(4'h3), .TIMEOUT(TMO)) dut (
    .CLK       (CLK),
    .RSTN      (RSTN),
    .B_UTIL    (B_UTIL),
    .B_RW      (B_RW),
    .B_BUS_IN  (B_BUS_IN),
    .B_BUS_OUT (B_BUS_OUT),
    .B_ACK     (B_ACK),
    .S_ADDR    (S_ADDR),
    .S_WDATA   (S_WDATA),
    .S_WE      (S_WE),
    .S_RE      (S_RE),
    .S_RDATA   (S_RDATA),
    .S_BSY     (S_BSY)
  );

  always #5 CLK = ~CLK;

  // Local store model: data appears the cycle after the read strobe.
  always @(posedge CLK) if (S_RE) rdata_q <= mem_byte;
  assign S_RDATA = rdata_q;

  typedef struct {
    logic [15:0] addr;
    logic        rw;
    logic [7:0]  data;
    int          pause_at;
    logic [3:0]  exp_acka;
    logic [3:0]  exp_re;
    logic [3:0]  exp_pack;
    logic [3:0]  exp_pwe;
    logic [7:0]  exp_rbits;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One bus cycle: sample the outputs of this cycle, then present its inputs.
  task automatic cyc(input logic util, input logic b);
    @(negedge CLK);
    s_ack   = B_ACK;
    s_out   = B_BUS_OUT;
    s_we    = S_WE;
    s_re    = S_RE;
    s_bsy   = S_BSY;
    s_addr  = S_ADDR;
    s_wdata = S_WDATA;
    B_UTIL   = util;
    B_BUS_IN = b;
  endtask

  task automatic apply_vec(input int i);
    vec_t        v;
    logic [3:0]  acka, re, pack, pwe, pout;
    logic [7:0]  rbits, wcap;
    logic [11:0] acap, wacap;
    logic        hold_ok, bsy_w0;
    v = vecs[i];
    acka = '0; re = '0; pack = '0; pwe = '0; pout = '0;
    rbits = '0; wcap = '0; acap = '0; wacap = '0; hold_ok = 1'b1; bsy_w0 = 1'b0;
    B_RW = v.rw;
    mem_byte = v.data;
    for (int k = 0; k < 16; k++) cyc(1'b1, v.addr[k]);
    for (int k = 0; k < 4; k++) begin
      cyc(1'b0, 1'b0);
      acka[k] = s_ack;
      re[k]   = s_re;
      if (k == 0) begin
        acap   = s_addr;
        bsy_w0 = s_bsy;
      end
    end
    if (acka != 4'b0000) begin
      for (int k = 0; k < 8; k++) begin
        if (v.rw) begin
          cyc(1'b1, v.data[k]);
        end else begin
          if (k == v.pause_at) begin
            repeat (5) begin
              cyc(1'b0, 1'b0);
              if (s_out !== v.exp_rbits[k]) hold_ok = 1'b0;
            end
          end
          cyc(1'b1, 1'b0);
          rbits[k] = s_out;
        end
      end
    end
    for (int k = 0; k < 4; k++) begin
      cyc(1'b0, 1'b0);
      pack[k] = s_ack;
      pwe[k]  = s_we;
      pout[k] = s_out;
      if (s_we) begin
        wcap  = s_wdata;
        wacap = s_addr;
      end
    end
    cyc(1'b0, 1'b0);
    check($sformatf("v%0d acka_mask", i), 32'(acka), 32'(v.exp_acka));
    check($sformatf("v%0d re_mask", i), 32'(re), 32'(v.exp_re));
    check($sformatf("v%0d post_ack_mask", i), 32'(pack), 32'(v.exp_pack));
    check($sformatf("v%0d post_we_mask", i), 32'(pwe), 32'(v.exp_pwe));
    check($sformatf("v%0d post_bus_out", i), 32'(pout), 32'd0);
    check($sformatf("v%0d s_addr_w0", i), 32'(acap), 32'(v.addr[11:0]));
    check($sformatf("v%0d busy_w0", i), 32'(bsy_w0), 32'd1);
    check($sformatf("v%0d busy_end", i), 32'(s_bsy), 32'd0);
    if (v.exp_pwe != 4'b0000)
      check($sformatf("v%0d we_addr_data", i), 32'({wacap, wcap}), 32'({v.addr[11:0], v.data}));
    if (!v.rw && v.exp_acka != 4'b0000)
      check($sformatf("v%0d read_bits", i), 32'(rbits), 32'(v.exp_rbits));
    if (v.pause_at >= 0)
      check($sformatf("v%0d hold_bit", i), 32'(hold_ok), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [15:0] a;
    logic [7:0]  d;
    logic        we_seen;

    //           addr      rw    data  pause acka     re       pack     pwe      rbits
    vecs[0] = '{16'h3A5C, 1'b1, 8'hB7, -1, 4'b1110, 4'b0000, 4'b1110, 4'b0001, 8'h00};
    vecs[1] = '{16'h3010, 1'b0, 8'h96, -1, 4'b1110, 4'b0001, 4'b0000, 4'b0000, 8'h96};
    vecs[2] = '{16'h7010, 1'b1, 8'h55, -1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 8'h00};
    vecs[3] = '{16'h3FFF, 1'b1, 8'h81, -1, 4'b1110, 4'b0000, 4'b1110, 4'b0001, 8'h00};
    vecs[4] = '{16'h3ABC, 1'b0, 8'h96,  3, 4'b1110, 4'b0001, 4'b0000, 4'b0000, 8'h96};
    vecs[5] = '{16'h2010, 1'b0, 8'h3C, -1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 8'h00};
    vecs[6] = '{16'h3000, 1'b0, 8'h5A, -1, 4'b1110, 4'b0001, 4'b0000, 4'b0000, 8'h5A};

    #1 RSTN = 1'b0;
    repeat (2) @(negedge CLK);
    check("reset_outputs", 32'({S_BSY, B_ACK, B_BUS_OUT, S_WE, S_RE, S_ADDR, S_WDATA}), 32'd0);
    RSTN = 1'b1;
    cyc(1'b0, 1'b0);

    // Address phase broken by a B_UTIL gap after 5 bits.
    B_RW = 1'b1;
    repeat (5) cyc(1'b1, 1'b1);
    cyc(1'b0, 1'b0);
    check("abort_busy_in_addr", 32'(s_bsy), 32'd1);
    cyc(1'b0, 1'b0);
    check("abort_idle", 32'({s_bsy, s_ack, s_re}), 32'd0);

    for (int i = 0; i < 7; i++) apply_vec(i);

    // Write frame stalls after 4 data bits until the data-phase timeout fires.
    a = 16'h3A5C;
    d = 8'hB7;
    B_RW = 1'b1;
    we_seen = 1'b0;
    for (int k = 0; k < 16; k++) cyc(1'b1, a[k]);
    repeat (4) cyc(1'b0, 1'b0);
    for (int k = 0; k < 4; k++) cyc(1'b1, d[k]);
    for (int k = 1; k <= TMO; k++) begin
      cyc(1'b0, 1'b0);
      we_seen |= s_we;
      if (k == TMO) check("busy_last_timeout_cycle", 32'(s_bsy), 32'd1);
    end
    cyc(1'b0, 1'b0);
    we_seen |= s_we;
    check("timeout_idle", 32'(s_bsy), 32'd0);
    repeat (4) begin
      cyc(1'b0, 1'b0);
      we_seen |= s_we;
    end
    check("timeout_no_we", 32'(we_seen), 32'd0);

    // Reset asserted while write data bit 5 is on the wire.
    we_seen = 1'b0;
    for (int k = 0; k < 16; k++) cyc(1'b1, a[k]);
    repeat (4) cyc(1'b0, 1'b0);
    for (int k = 0; k < 6; k++) cyc(1'b1, d[k]);
    #2 RSTN = 1'b0;
    #1 check("async_reset_outputs", 32'({S_BSY, B_ACK, B_BUS_OUT, S_WE, S_RE, S_ADDR, S_WDATA}), 32'd0);
    B_UTIL = 1'b0;
    repeat (3) begin
      cyc(1'b0, 1'b0);
      we_seen |= s_we;
    end
    RSTN = 1'b1;
    repeat (3) begin
      cyc(1'b0, 1'b0);
      we_seen |= s_we;
    end
    check("reset_no_we", 32'(we_seen), 32'd0);
    apply_vec(0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
